rx_frame_authenticator: RTL

// - Receive-side stage directly downstream of the ChaCha decrypt core in the receiver path.
// - Takes a decrypted 512-bit frame {msg[487:0], cntr[15:0], auth[7:0]} and verifies the 8-bit auth tag.
// - Enforces anti-replay on the 16-bit frame counter.
// - Forwards the 488-bit plaintext on success; drops the frame and flags the error on failure.

---
 rtl/rx_frame_authenticator.sv | 87 ++++++++
 1 files changed

// File: rtl/rx_frame_authenticator.sv
// rx_frame_authenticator: checks the byte-XOR tag and anti-replay window of decrypted frames
// and forwards the plaintext of frames that pass both checks.
module rx_frame_authenticator #(
   parameter int FRAMED_TOTAL_WIDTH = 512,
   parameter int MSG_WIDTH          = 488,
   parameter int FRAMER_CNTR_WIDTH  = 16,
   parameter int FRAMER_AUTH_WIDTH  = 8,
   parameter int REPLAY_WINDOW      = 16,
   parameter int ERR_CNT_WIDTH      = 8
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic [FRAMED_TOTAL_WIDTH-1:0] frame_data_in,
   input  logic                          ready_in,
   output logic                          valid_out,
   output logic [MSG_WIDTH-1:0]          plaintext_data_out,
   output logic                          auth_err,
   output logic                          replay_err,
   output logic [ERR_CNT_WIDTH-1:0]      err_count
);
   localparam int CW = FRAMER_CNTR_WIDTH;
   localparam int AW = FRAMER_AUTH_WIDTH;
   localparam int NB = (FRAMED_TOTAL_WIDTH - AW) / 8;
   localparam logic [CW-1:0] WIN = CW'(REPLAY_WINDOW);
   localparam logic [1:0] IDLE = 2'd0, CHECK = 2'd1, OUT = 2'd2;

   logic [1:0]                    state;
   logic [FRAMED_TOTAL_WIDTH-1:0] frame;
   logic [CW-1:0]                 expected_cntr;
   logic [CW-1:0]                 rx_cntr;
   logic [CW-1:0]                 diff;
   logic [AW-1:0]                 auth_calc;
   logic                          tag_ok;
   logic                          win_ok;

   assign rx_cntr   = frame[AW +: CW];
   assign diff      = rx_cntr - expected_cntr;
   assign win_ok    = diff < WIN;
   assign tag_ok    = auth_calc == frame[AW-1:0];
   assign ready_out = state == IDLE;

   always_comb begin
      auth_calc = '0;
      for (int k = 0; k < NB; k++) auth_calc ^= frame[8*k+AW +: 8];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state              <= IDLE;
         frame              <= '0;
         expected_cntr      <= '0;
         valid_out          <= 1'b0;
         plaintext_data_out <= '0;
         auth_err           <= 1'b0;
         replay_err         <= 1'b0;
         err_count          <= '0;
      end else begin
         auth_err   <= 1'b0;
         replay_err <= 1'b0;
         case (state)
            IDLE: if (valid_in) begin
               frame <= frame_data_in;
               state <= CHECK;
            end
            CHECK: if (tag_ok && win_ok) begin
               plaintext_data_out <= frame[FRAMED_TOTAL_WIDTH-1 -: MSG_WIDTH];
               valid_out          <= 1'b1;
               expected_cntr      <= rx_cntr + CW'(1);
               state              <= OUT;
            end else begin
               // a bad tag masks any counter failure
               auth_err   <= !tag_ok;
               replay_err <= tag_ok;
               if (err_count != '1) err_count <= err_count + ERR_CNT_WIDTH'(1);
               state      <= IDLE;
            end
            OUT: if (ready_in) begin
               valid_out <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
